// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit. It range-checks each request and splits a
//            misaligned half or word into byte beats toward data_mem.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_LBU = 3'b100;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_write;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_misalign;
    logic [1:0]  r_beat;
    logic [1:0]  r_last;
    logic [31:0] r_acc;

    logic [2:0]  w_size;
    logic        w_illegal;
    logic [32:0] w_end;
    logic        w_fault;
    logic        w_misalign;
    logic        w_beat_last;
    logic [4:0]  w_shift;
    logic [31:0] w_assembled;
    logic [31:0] w_ext;
    logic [31:0] w_load_result;

    // Request decode: size, legality and a 33-bit range check that cannot wrap
    always_comb begin
        case (req_func3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        if (req_write)
            w_illegal = (req_func3 > 3'b010);
        else
            w_illegal = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11);
        w_end      = {1'b0, req_addr} + {30'd0, w_size};
        w_fault    = w_illegal || (w_end > 33'(MEM_SIZE));
        w_misalign = ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ((req_func3[1:0] == 2'b01) && req_addr[0]);
    end

    // Current load byte merged into the accumulator, then extended per funct3
    always_comb begin
        w_shift     = {r_beat, 3'b000};
        w_assembled = r_acc;
        w_assembled[w_shift +: 8] = mem_data_out[7:0];
        case (r_func3)
            3'b001:  w_ext = {{16{w_assembled[15]}}, w_assembled[15:0]};
            3'b101:  w_ext = {16'd0, w_assembled[15:0]};
            default: w_ext = w_assembled;
        endcase
        w_load_result = r_misalign ? w_ext : mem_data_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_beat_last    = 1'b0;
        req_ready      = 1'b0;
        stall          = 1'b0;
        mem_addr       = 32'd0;
        mem_write_data = 32'd0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_func3      = 3'd0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !w_fault)
                    w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                stall     = 1'b1;
                mem_read  = ~r_write;
                mem_write = r_write;
                mem_addr  = r_addr + {30'd0, r_beat};
                if (r_misalign) begin
                    mem_func3      = r_write ? c_F3_SB : c_F3_LBU;
                    mem_write_data = {24'd0, r_wdata[w_shift +: 8]};
                end else begin
                    mem_func3      = r_func3;
                    mem_write_data = r_wdata;
                end
                if (r_beat == r_last) begin
                    w_beat_last  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_func3    <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_misalign <= 1'b0;
            r_beat     <= 2'd0;
            r_last     <= 2'd0;
            r_acc      <= 32'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_fault  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (r_state == ST_IDLE && req_valid) begin
                if (w_fault) begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b1;
                    rsp_rdata <= 32'd0;
                end else begin
                    r_write    <= req_write;
                    r_func3    <= req_func3;
                    r_addr     <= req_addr;
                    r_wdata    <= req_wdata;
                    r_misalign <= w_misalign;
                    r_beat     <= 2'd0;
                    r_acc      <= 32'd0;
                    r_last     <= w_misalign ? 2'(w_size - 3'd1) : 2'd0;
                end
            end else if (r_state == ST_ACCESS) begin
                r_acc  <= w_assembled;
                r_beat <= r_beat + 2'd1;
                if (w_beat_last) begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= r_write ? 32'd0 : w_load_result;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Scoreboard bench for lsu_ctrl with a byte-array data_mem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  mem_func3;
    logic [31:0] mem_data_out;

    lsu_ctrl #(.MEM_SIZE(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_func3      (req_func3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .stall          (stall),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_func3      (mem_func3),
        .mem_data_out   (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        longint      t_acc;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
    } beat_t;
    beat_t blog[$];

    // data_mem model: byte array, combinational read, write on rising edge
    logic [7:0] mem [0:1023];
    bit         mem_inited = 1'b0;
    logic [9:0] ma;
    logic [7:0] b0, b1, b2, b3;

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem_inited <= 1'b1;
        end else if (mem_write) begin
            case (mem_func3)
                3'b000: mem[mem_addr[9:0]] <= mem_write_data[7:0];
                3'b001: begin
                    mem[mem_addr[9:0]]         <= mem_write_data[7:0];
                    mem[mem_addr[9:0] + 10'd1] <= mem_write_data[15:8];
                end
                3'b010: begin
                    mem[mem_addr[9:0]]         <= mem_write_data[7:0];
                    mem[mem_addr[9:0] + 10'd1] <= mem_write_data[15:8];
                    mem[mem_addr[9:0] + 10'd2] <= mem_write_data[23:16];
                    mem[mem_addr[9:0] + 10'd3] <= mem_write_data[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ma = mem_addr[9:0];
        b0 = mem[ma];
        b1 = mem[ma + 10'd1];
        b2 = mem[ma + 10'd2];
        b3 = mem[ma + 10'd3];
        case (mem_func3)
            3'b000:  mem_data_out = {{24{b0[7]}}, b0};
            3'b001:  mem_data_out = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_data_out = {b3, b2, b1, b0};
            3'b100:  mem_data_out = {24'd0, b0};
            3'b101:  mem_data_out = {16'd0, b1, b0};
            default: mem_data_out = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, " fault"}, {31'd0, rsp_fault}, {31'd0, e.fault});
                chk({e.name, " rdata"}, rsp_rdata, e.rdata);
                chk({e.name, " latency_ns"}, 32'($time - e.t_acc), 32'(10 * e.lat + 5));
            end
        end
    end

    // Memory-port logger and idle/exclusivity monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall)
                blog.push_back('{mem_write, mem_read, mem_func3, mem_addr, mem_write_data});
            checks++;
            if ((mem_read && mem_write) ||
                (!stall && (mem_read || mem_write || mem_addr != 0 ||
                            mem_write_data != 0 || mem_func3 != 0))) begin
                errors++;
                $display("FAIL mem_port: got rd=%0b wr=%0b addr=0x%08h stall=%0b, expected exclusive and quiet when idle",
                         mem_read, mem_write, mem_addr, stall);
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic efault, input logic [31:0] erd,
                         input int lat, input bit push, input string name);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({name, " req_ready_timeout"}, {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        if (push) sb.push_back('{efault, erd, lat, $time, name});
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) chk({name, " done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_beat(input string name, input int k, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (blog.size() <= k) begin
            chk({name, " beat_missing"}, 32'(blog.size()), 32'(k + 1));
            return;
        end
        chk({name, " beat_wr"}, {31'd0, blog[k].wr}, {31'd0, wr});
        chk({name, " beat_rd"}, {31'd0, blog[k].rd}, {31'd0, ~wr});
        chk({name, " beat_f3"}, {29'd0, blog[k].f3}, {29'd0, f3});
        chk({name, " beat_addr"}, blog[k].addr, addr);
        if (wr) chk({name, " beat_wdata"}, blog[k].wd, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_func3 = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #12;
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp", {rsp_valid, rsp_fault, stall, mem_write, mem_read, mem_func3, 24'd0}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst mem_addr", mem_addr | mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned word store then load
        blog.delete();
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, 1, "sw_0x10");
        wait_done("sw_0x10");
        chk("sw_0x10 beats", 32'(blog.size()), 32'd1);
        chk_beat("sw_0x10", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1, 1, "lw_0x10");
        wait_done("lw_0x10");

        // Misaligned word store: four SB beats
        blog.delete();
        issue(1'b1, 3'b010, 32'h21, 32'h11223344, 1'b0, 32'h0, 4, 1, "sw_0x21");
        wait_done("sw_0x21");
        chk("sw_0x21 stall_cycles", 32'(blog.size()), 32'd4);
        chk_beat("sw_0x21 b0", 0, 1'b1, 3'b000, 32'h21, 32'h44);
        chk_beat("sw_0x21 b1", 1, 1'b1, 3'b000, 32'h22, 32'h33);
        chk_beat("sw_0x21 b2", 2, 1'b1, 3'b000, 32'h23, 32'h22);
        chk_beat("sw_0x21 b3", 3, 1'b1, 3'b000, 32'h24, 32'h11);
        blog.delete();
        issue(1'b0, 3'b010, 32'h21, 32'h0, 1'b0, 32'h11223344, 4, 1, "lw_0x21");
        wait_done("lw_0x21");
        chk("lw_0x21 beats", 32'(blog.size()), 32'd4);
        chk_beat("lw_0x21 b0", 0, 1'b0, 3'b100, 32'h21, 32'h0);
        chk_beat("lw_0x21 b3", 3, 1'b0, 3'b100, 32'h24, 32'h0);

        // Misaligned halfword loads, signed and unsigned
        issue(1'b1, 3'b000, 32'h31, 32'hAAAAAA80, 1'b0, 32'h0, 1, 1, "sb_0x31");
        issue(1'b1, 3'b000, 32'h32, 32'h000000FF, 1'b0, 32'h0, 1, 1, "sb_0x32");
        issue(1'b0, 3'b001, 32'h31, 32'h0, 1'b0, 32'hFFFFFF80, 2, 1, "lh_0x31");
        issue(1'b0, 3'b101, 32'h31, 32'h0, 1'b0, 32'h0000FF80, 2, 1, "lhu_0x31");

        // Aligned sub-word loads of 0xDEADBEEF at 0x10
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 1, 1, "lb_0x13");
        issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 1, 1, "lhu_0x12");
        wait_done("sub_word");

        // Range and funct3 faults, back to back
        blog.delete();
        issue(1'b0, 3'b010, 32'd1022, 32'h0, 1'b1, 32'h0, 0, 1, "lw_1022");
        wait_done("lw_1022");
        chk("lw_1022 no_access", 32'(blog.size()), 32'd0);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0, 0, 1, "lw_wrap");
        issue(1'b1, 3'b011, 32'h40, 32'h12345678, 1'b1, 32'h0, 0, 1, "st_f3_011");
        issue(1'b0, 3'b110, 32'h40, 32'h0, 1'b1, 32'h0, 0, 1, "ld_f3_110");
        issue(1'b0, 3'b010, 32'd1020, 32'h0, 1'b0, 32'h0, 1, 1, "lw_1020");
        wait_done("faults");
        chk("faults no_access", 32'(blog.size()), 32'd1);

        // Reset during beat 2 of a misaligned store
        blog.delete();
        issue(1'b1, 3'b010, 32'h41, 32'hA1B2C3D4, 1'b0, 32'h0, 4, 0, "sw_rst");
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("sw_rst beat2_addr", mem_addr, 32'h43);
        chk("sw_rst beat2_write", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst write_drop", {31'd0, mem_write}, 32'd0);
        chk("sw_rst stall_drop", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sw_rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("sw_rst no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("sw_rst beats_logged", 32'(blog.size()), 32'd2);
        issue(1'b0, 3'b010, 32'h41, 32'h0, 1'b0, 32'h0000C3D4, 4, 1, "lw_0x41");
        wait_done("lw_0x41");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
